// File: rtl/ps2_key_matrix.sv
// PS/2 set-2 keyboard front-end for the Galaksija core.
// Receives scancode frames, decodes make/break/extended sequences into a
// 64-entry key-state matrix and serves that matrix to the CPU read path.
module ps2_key_matrix #(
    parameter int TIMEOUT_CYCLES = 50000,
    parameter int SYNC_STAGES    = 3
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       ps2_clk,
    input  logic       ps2_dat,
    input  logic       clear,
    input  logic       key_rd,
    input  logic [5:0] key_addr,
    output logic [7:0] key_out,
    output logic       scan_valid,
    output logic [7:0] scan_code,
    output logic       frame_err
);

    localparam int TMO_W = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT_CYCLES - 1);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_CHECK = 2'd2
    } rx_state_t;

    // Odd parity holds when data plus parity bit carry an odd number of ones.
    function automatic logic odd_parity_ok(input logic [8:0] bits);
        return ^bits;
    endfunction

    // Scancode to Galaksija key index; bit 6 flags a mapped code.
    function automatic logic [6:0] map_key(input logic ext, input logic [7:0] code);
        logic [6:0] res;
        case ({ext, code})
            9'h01C: res = {1'b1, 6'd1};
            9'h032: res = {1'b1, 6'd2};
            9'h021: res = {1'b1, 6'd3};
            9'h023: res = {1'b1, 6'd4};
            9'h024: res = {1'b1, 6'd5};
            9'h02B: res = {1'b1, 6'd6};
            9'h034: res = {1'b1, 6'd7};
            9'h033: res = {1'b1, 6'd8};
            9'h043: res = {1'b1, 6'd9};
            9'h03B: res = {1'b1, 6'd10};
            9'h042: res = {1'b1, 6'd11};
            9'h04B: res = {1'b1, 6'd12};
            9'h03A: res = {1'b1, 6'd13};
            9'h031: res = {1'b1, 6'd14};
            9'h044: res = {1'b1, 6'd15};
            9'h04D: res = {1'b1, 6'd16};
            9'h015: res = {1'b1, 6'd17};
            9'h02D: res = {1'b1, 6'd18};
            9'h01B: res = {1'b1, 6'd19};
            9'h02C: res = {1'b1, 6'd20};
            9'h03C: res = {1'b1, 6'd21};
            9'h02A: res = {1'b1, 6'd22};
            9'h01D: res = {1'b1, 6'd23};
            9'h022: res = {1'b1, 6'd24};
            9'h035: res = {1'b1, 6'd25};
            9'h01A: res = {1'b1, 6'd26};
            9'h045: res = {1'b1, 6'd32};
            9'h016: res = {1'b1, 6'd33};
            9'h01E: res = {1'b1, 6'd34};
            9'h026: res = {1'b1, 6'd35};
            9'h025: res = {1'b1, 6'd36};
            9'h02E: res = {1'b1, 6'd37};
            9'h036: res = {1'b1, 6'd38};
            9'h03D: res = {1'b1, 6'd39};
            9'h03E: res = {1'b1, 6'd40};
            9'h046: res = {1'b1, 6'd41};
            9'h029: res = {1'b1, 6'd31};
            9'h05A: res = {1'b1, 6'd48};
            9'h076: res = {1'b1, 6'd49};
            9'h066: res = {1'b1, 6'd29};
            9'h012: res = {1'b1, 6'd53};
            9'h059: res = {1'b1, 6'd53};
            9'h175: res = {1'b1, 6'd27};
            9'h172: res = {1'b1, 6'd28};
            9'h16B: res = {1'b1, 6'd29};
            9'h174: res = {1'b1, 6'd30};
            default: res = 7'd0;
        endcase
        return res;
    endfunction

    logic [SYNC_STAGES-1:0] r_clk_sync;
    logic [SYNC_STAGES-1:0] r_dat_sync;
    logic                   r_clk_prev;
    rx_state_t              r_state;
    rx_state_t              w_state_next;
    logic [3:0]             r_bitcnt;
    logic [9:0]             r_shift;
    logic [TMO_W-1:0]       r_tmo;
    logic                   r_scan_valid;
    logic [7:0]             r_scan_code;
    logic                   r_frame_err;
    logic [63:0]            r_keys;
    logic                   r_brk;
    logic                   r_ext;
    logic [7:0]             r_key_out;

    logic                   w_clk_s;
    logic                   w_dat_s;
    logic                   w_fall;
    logic                   w_good;
    logic                   w_err;
    logic                   w_tmo_hit;
    logic [6:0]             w_map;

    assign w_clk_s = r_clk_sync[SYNC_STAGES-1];
    assign w_dat_s = r_dat_sync[SYNC_STAGES-1];
    assign w_fall  = r_clk_prev & ~w_clk_s;
    assign w_map   = map_key(r_ext, r_scan_code);

    // Bring the asynchronous PS/2 lines into the clk domain; idle level is high.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_clk_sync <= {SYNC_STAGES{1'b1}};
            r_dat_sync <= {SYNC_STAGES{1'b1}};
            r_clk_prev <= 1'b1;
        end else begin
            r_clk_sync <= {r_clk_sync[SYNC_STAGES-2:0], ps2_clk};
            r_dat_sync <= {r_dat_sync[SYNC_STAGES-2:0], ps2_dat};
            r_clk_prev <= w_clk_s;
        end
    end

    // Receiver state register.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Receiver next-state logic plus the good/error/timeout events it raises.
    always_comb begin
        w_state_next = r_state;
        w_good       = 1'b0;
        w_err        = 1'b0;
        w_tmo_hit    = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (w_fall) begin
                    if (!w_dat_s) begin
                        w_state_next = ST_SHIFT;
                    end else begin
                        w_err = 1'b1;
                    end
                end else begin
                    w_state_next = ST_IDLE;
                end
            end
            ST_SHIFT: begin
                if (w_fall) begin
                    if (r_bitcnt == 4'd9) begin
                        w_state_next = ST_CHECK;
                    end else begin
                        w_state_next = ST_SHIFT;
                    end
                end else if (r_tmo == TMO_LAST) begin
                    // Device stalled mid-frame: drop it silently.
                    w_tmo_hit    = 1'b1;
                    w_state_next = ST_IDLE;
                end else begin
                    w_state_next = ST_SHIFT;
                end
            end
            ST_CHECK: begin
                w_state_next = ST_IDLE;
                if (odd_parity_ok(r_shift[8:0]) && r_shift[9]) begin
                    w_good = 1'b1;
                end else begin
                    w_err = 1'b1;
                end
            end
            default: begin
                w_state_next = ST_IDLE;
            end
        endcase
    end

    // Shift data/parity/stop LSB-first and count edges within a frame.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_bitcnt <= 4'd0;
            r_shift  <= 10'd0;
        end else if (r_state == ST_SHIFT && w_fall) begin
            r_bitcnt <= r_bitcnt + 4'd1;
            r_shift  <= {w_dat_s, r_shift[9:1]};
        end else if (r_state != ST_SHIFT) begin
            r_bitcnt <= 4'd0;
        end else begin
            r_bitcnt <= r_bitcnt;
        end
    end

    // Inactivity counter: restarts on each falling edge, runs only mid-frame.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_tmo <= '0;
        end else if (w_fall || w_tmo_hit || r_state != ST_SHIFT) begin
            r_tmo <= '0;
        end else begin
            r_tmo <= r_tmo + TMO_W'(1);
        end
    end

    // Registered receiver outputs: one-cycle pulses and the last good byte.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_scan_valid <= 1'b0;
            r_frame_err  <= 1'b0;
            r_scan_code  <= 8'h00;
        end else begin
            r_scan_valid <= w_good;
            r_frame_err  <= w_err;
            if (w_good) begin
                r_scan_code <= r_shift[7:0];
            end else begin
                r_scan_code <= r_scan_code;
            end
        end
    end

    // Sequence decoder and key matrix; clear takes priority over a decode.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_keys <= 64'd0;
            r_brk  <= 1'b0;
            r_ext  <= 1'b0;
        end else if (clear) begin
            r_keys <= 64'd0;
            r_brk  <= 1'b0;
            r_ext  <= 1'b0;
        end else if (r_scan_valid) begin
            if (r_scan_code == 8'hF0) begin
                r_brk <= 1'b1;
            end else if (r_scan_code == 8'hE0) begin
                r_ext <= 1'b1;
            end else begin
                if (w_map[6]) begin
                    r_keys[w_map[5:0]] <= ~r_brk;
                end
                r_brk <= 1'b0;
                r_ext <= 1'b0;
            end
        end
    end

    // CPU read port: registered lookup of the matrix as it stood before this edge.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_key_out <= 8'hFF;
        end else if (key_rd) begin
            r_key_out <= r_keys[key_addr] ? 8'hFE : 8'hFF;
        end else begin
            r_key_out <= r_key_out;
        end
    end

    assign key_out    = r_key_out;
    assign scan_valid = r_scan_valid;
    assign scan_code  = r_scan_code;
    assign frame_err  = r_frame_err;

endmodule

// File: tb/tb_ps2_key_matrix.sv
// Directed bench for ps2_key_matrix: PS/2 frames are driven bit by bit, a
// reference model of the key matrix and expected receive events is kept in
// the bench, and a compare process checks outputs every cycle.
module tb_ps2_key_matrix;

    localparam int TMO  = 200;
    localparam int HALF = 10;

    logic       clk      = 1'b0;
    logic       reset_n  = 1'b0;
    logic       ps2_clk  = 1'b1;
    logic       ps2_dat  = 1'b1;
    logic       clear    = 1'b0;
    logic       key_rd   = 1'b0;
    logic [5:0] key_addr = 6'd0;
    logic [7:0] key_out;
    logic       scan_valid;
    logic [7:0] scan_code;
    logic       frame_err;

    ps2_key_matrix #(.TIMEOUT_CYCLES(TMO), .SYNC_STAGES(3)) dut (
        .clk(clk), .reset_n(reset_n), .ps2_clk(ps2_clk), .ps2_dat(ps2_dat),
        .clear(clear), .key_rd(key_rd), .key_addr(key_addr), .key_out(key_out),
        .scan_valid(scan_valid), .scan_code(scan_code), .frame_err(frame_err)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    // Reference model
    int         map_n[256];
    int         map_e[256];
    bit         mkeys[64];
    bit         mbrk;
    bit         mext;
    logic [7:0] exp_key_out   = 8'hFF;
    logic [7:0] exp_scan_code = 8'h00;

    typedef struct {
        bit         good;
        logic [7:0] code;
    } ev_t;
    ev_t exp_q[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, req, $time);
        end
    endtask

    task automatic model_byte(input logic [7:0] b);
        int idx;
        if (b == 8'hF0) begin
            mbrk = 1'b1;
        end else if (b == 8'hE0) begin
            mext = 1'b1;
        end else begin
            idx = mext ? map_e[b] : map_n[b];
            if (idx != 0) mkeys[idx] = !mbrk;
            mbrk = 1'b0;
            mext = 1'b0;
        end
    endtask

    task automatic model_clear();
        for (int i = 0; i < 64; i++) mkeys[i] = 1'b0;
        mbrk = 1'b0;
        mext = 1'b0;
    endtask

    // Compare process: outputs against the model on every cycle.
    always @(negedge clk) begin
        ev_t ev;
        if (!reset_n) begin
            exp_key_out   = 8'hFF;
            exp_scan_code = 8'h00;
            chk("rst_key_out", key_out, 8'hFF);
            chk("rst_scan_code", scan_code, 8'h00);
            chk("rst_scan_valid", scan_valid, 1'b0);
            chk("rst_frame_err", frame_err, 1'b0);
        end else begin
            if (scan_valid || frame_err) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_pulse", {scan_valid, frame_err}, 2'b00);
                end else begin
                    ev = exp_q.pop_front();
                    chk("pulse_kind", {scan_valid, frame_err}, ev.good ? 2'b10 : 2'b01);
                    if (ev.good) exp_scan_code = ev.code;
                end
            end
            chk("scan_code", scan_code, exp_scan_code);
            chk("key_out", key_out, exp_key_out);
        end
    end

    task automatic ps2_bit(input logic b);
        @(posedge clk); #1 ps2_dat = b;
        repeat (HALF) @(posedge clk);
        #1 ps2_clk = 1'b0;
        repeat (HALF) @(posedge clk);
        #1 ps2_clk = 1'b1;
    endtask

    // Drive nbits of a frame; optionally flip parity, use a bad start bit, or
    // raise clear in the same cycle the decoder acts on the final byte.
    task automatic send_frame(input logic [7:0] b, input bit flip_par, input bit bad_start,
                              input int nbits, input bit clr_on_valid);
        logic [10:0] f;
        int k;
        f = {1'b1, (~^b) ^ flip_par, b, bad_start};
        if (bad_start) exp_q.push_back('{good: 1'b0, code: 8'h00});
        else if (nbits == 11) exp_q.push_back('{good: !flip_par, code: b});
        for (int i = 0; i < nbits; i++) begin
            if (i == 10 && clr_on_valid) begin
                @(posedge clk); #1 ps2_dat = f[i];
                repeat (HALF) @(posedge clk);
                #1 ps2_clk = 1'b0;
                k = 0;
                while (!scan_valid && k < 40) begin
                    @(negedge clk);
                    k++;
                end
                if (k >= 40) chk("clear_sync_timeout", 1, 0);
                clear = 1'b1;
                @(posedge clk); #1 clear = 1'b0;
                repeat (HALF) @(posedge clk);
                #1 ps2_clk = 1'b1;
            end else begin
                ps2_bit(f[i]);
            end
        end
    endtask

    task automatic frame_done(input logic [7:0] b, input bit good);
        int k;
        k = 0;
        while (exp_q.size() != 0 && k < 50) begin
            @(posedge clk);
            k++;
        end
        chk("event_seen", exp_q.size(), 0);
        exp_q.delete();
        repeat (4) @(posedge clk);
        if (good) model_byte(b);
    endtask

    task automatic send(input logic [7:0] b);
        send_frame(b, 1'b0, 1'b0, 11, 1'b0);
        frame_done(b, 1'b1);
    endtask

    task automatic read(input logic [5:0] addr, input logic [7:0] lit, input string name);
        logic [7:0] e;
        @(posedge clk); #1 key_rd = 1'b1;
        key_addr = addr;
        e = mkeys[addr] ? 8'hFE : 8'hFF;
        chk({name, "_model"}, e, lit);
        @(posedge clk); #1 key_rd = 1'b0;
        exp_key_out = e;
        @(negedge clk);
        chk(name, key_out, lit);
    endtask

    task automatic do_reset();
        @(posedge clk); #1 reset_n = 1'b0;
        model_clear();
        exp_q.delete();
        repeat (3) @(posedge clk);
        #1 reset_n = 1'b1;
        repeat (10) @(posedge clk);
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0] letters[26];
        logic [7:0] digits[10];
        letters = '{8'h1C, 8'h32, 8'h21, 8'h23, 8'h24, 8'h2B, 8'h34, 8'h33, 8'h43,
                    8'h3B, 8'h42, 8'h4B, 8'h3A, 8'h31, 8'h44, 8'h4D, 8'h15, 8'h2D,
                    8'h1B, 8'h2C, 8'h3C, 8'h2A, 8'h1D, 8'h22, 8'h35, 8'h1A};
        digits  = '{8'h45, 8'h16, 8'h1E, 8'h26, 8'h25, 8'h2E, 8'h36, 8'h3D, 8'h3E, 8'h46};
        for (int i = 0; i < 256; i++) begin
            map_n[i] = 0;
            map_e[i] = 0;
        end
        for (int i = 0; i < 26; i++) map_n[letters[i]] = i + 1;
        for (int i = 0; i < 10; i++) map_n[digits[i]] = 32 + i;
        map_n[8'h29] = 31; map_n[8'h5A] = 48; map_n[8'h76] = 49; map_n[8'h66] = 29;
        map_n[8'h12] = 53; map_n[8'h59] = 53;
        map_e[8'h75] = 27; map_e[8'h72] = 28; map_e[8'h6B] = 29; map_e[8'h74] = 30;
        model_clear();

        repeat (3) @(posedge clk);
        #1 reset_n = 1'b1;
        repeat (10) @(posedge clk);

        // Make and break of A
        send(8'h1C);
        read(6'd1, 8'hFE, "a_make");
        send(8'hF0); send(8'h1C);
        read(6'd1, 8'hFF, "a_break");

        // Extended left arrow
        send(8'hE0); send(8'h6B);
        read(6'd29, 8'hFE, "left_make");
        read(6'd30, 8'hFF, "right_idle1");
        send(8'hE0); send(8'hF0); send(8'h6B);
        read(6'd29, 8'hFF, "left_break");
        read(6'd30, 8'hFF, "right_idle2");

        // Shift plus digit 1 held together, typematic repeat
        send(8'h12); send(8'h16);
        read(6'd53, 8'hFE, "shift_make");
        read(6'd33, 8'hFE, "dig1_make");
        send(8'hF0); send(8'h12);
        read(6'd53, 8'hFF, "shift_break");
        read(6'd33, 8'hFE, "dig1_held");
        send(8'h16);
        read(6'd33, 8'hFE, "dig1_repeat");
        send(8'hF0); send(8'h16);
        read(6'd33, 8'hFF, "dig1_break");

        // Backspace shares index 29 with left arrow
        send(8'h66);
        read(6'd29, 8'hFE, "bksp_make");
        send(8'hF0); send(8'h66);
        read(6'd29, 8'hFF, "bksp_break");

        // Bad parity, bad start bit
        send_frame(8'h1C, 1'b1, 1'b0, 11, 1'b0);
        frame_done(8'h1C, 1'b0);
        read(6'd1, 8'hFF, "badpar_no_key");
        send_frame(8'h00, 1'b0, 1'b1, 1, 1'b0);
        frame_done(8'h00, 1'b0);

        // Stall mid-frame, then a clean frame
        send_frame(8'h00, 1'b0, 1'b0, 5, 1'b0);
        repeat (2 * TMO) @(posedge clk);
        send(8'h5A);
        read(6'd48, 8'hFE, "enter_after_tmo");

        // Reset mid-frame
        send_frame(8'h00, 1'b0, 1'b0, 5, 1'b0);
        do_reset();
        read(6'd48, 8'hFF, "enter_after_rst");
        send(8'h1C);
        read(6'd1, 8'hFE, "a_after_rst");

        // Esc, then a pending break discarded by clear
        send(8'h76);
        read(6'd49, 8'hFE, "esc_make");
        send(8'hF0);
        @(posedge clk); #1 clear = 1'b1;
        @(posedge clk); #1 clear = 1'b0;
        model_clear();
        send(8'h1C);
        read(6'd1, 8'hFE, "a_after_clear");
        read(6'd49, 8'hFF, "esc_cleared");

        // Clear in the same cycle as a decode
        send(8'h29);
        read(6'd31, 8'hFE, "space_make");
        read(6'd1, 8'hFE, "a_held");
        send_frame(8'h24, 1'b0, 1'b0, 11, 1'b1);
        frame_done(8'h24, 1'b1);
        model_clear();
        read(6'd1, 8'hFF, "clr_a");
        read(6'd31, 8'hFF, "clr_space");
        read(6'd5, 8'hFF, "clr_e");

        repeat (20) @(posedge clk);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
